// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//   MM:SS.mmm countdown timer. It has a 1 ms prescaler and an
//   IDLE/RUN/PAUSE/DONE control FSM. It drives four seven-segment digits
//   (active-low, bit6=g .. bit0=a) and shows the remaining milliseconds in
//   binary.
//
// Parameters
//   TICK_DIV    clk cycles per 1 ms tick (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   load        capture (clamped) preset_min/preset_sec, return to IDLE
//   preset_min  minutes preset, values above 99 clamp to 99
//   preset_sec  seconds preset, values above 59 clamp to 59
//   start       level: 1 = run, 0 = pause
//   HEX0..HEX3  sec units, sec tens, min units, min tens (seven-segment)
//   milesimos   remaining milliseconds 0-999
//   running     high in RUN
//   done        high in DONE
//   expired     single-cycle pulse on entry to DONE
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] preset_min,
    input  logic [5:0] preset_sec,
    input  logic       start,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [9:0] milesimos,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [6:0]      min_r;
    logic [5:0]      sec_r;
    logic [9:0]      ms_r;
    logic [PW-1:0]   presc_r;
    logic            running_r;
    logic            done_r;
    logic            expired_r;

    logic [6:0]      clamp_min_s;
    logic [5:0]      clamp_sec_s;
    logic [6:0]      dec_min_s;
    logic [5:0]      dec_sec_s;
    logic [9:0]      dec_ms_s;
    logic            zero_s;
    logic            reach_zero_s;
    logic            tick_s;

    // Seven-segment encoding, active-low; a non-digit blanks the display.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Tens digit of a 0-99 value.
    function automatic logic [3:0] tens_of(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    // Units digit of a 0-99 value.
    function automatic logic [3:0] ones_of(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    // Clamp presets to the displayable range.
    always_comb begin
        if (preset_min > 7'd99) begin
            clamp_min_s = 7'd99;
        end else begin
            clamp_min_s = preset_min;
        end
        if (preset_sec > 6'd59) begin
            clamp_sec_s = 6'd59;
        end else begin
            clamp_sec_s = preset_sec;
        end
    end

    // Next count after one tick; an all-zero count holds rather than wrapping.
    always_comb begin
        dec_min_s = min_r;
        dec_sec_s = sec_r;
        dec_ms_s  = ms_r;
        zero_s    = (min_r == 7'd0) && (sec_r == 6'd0) && (ms_r == 10'd0);
        if (zero_s) begin
            dec_ms_s = 10'd0;
        end else if (ms_r != 10'd0) begin
            dec_ms_s = ms_r - 10'd1;
        end else begin
            dec_ms_s = 10'd999;
            if (sec_r != 6'd0) begin
                dec_sec_s = sec_r - 6'd1;
            end else begin
                dec_sec_s = 6'd59;
                dec_min_s = min_r - 7'd1;
            end
        end
        reach_zero_s = (dec_min_s == 7'd0) && (dec_sec_s == 6'd0) && (dec_ms_s == 10'd0);
        tick_s       = (presc_r == PRESC_LAST);
    end

    // Control FSM, count registers, prescaler and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            min_r     <= 7'd0;
            sec_r     <= 6'd0;
            ms_r      <= 10'd0;
            presc_r   <= '0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            expired_r <= 1'b0;
        end else if (load) begin
            state_r   <= ST_IDLE;
            min_r     <= clamp_min_s;
            sec_r     <= clamp_sec_s;
            ms_r      <= 10'd0;
            presc_r   <= '0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            expired_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !zero_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Pausing wins over counting on the same edge; the prescaler keeps its phase.
                    if (!start) begin
                        state_r   <= ST_PAUSE;
                        running_r <= 1'b0;
                    end else if (tick_s) begin
                        presc_r <= '0;
                        min_r   <= dec_min_s;
                        sec_r   <= dec_sec_s;
                        ms_r    <= dec_ms_s;
                        if (reach_zero_s) begin
                            state_r   <= ST_DONE;
                            running_r <= 1'b0;
                            done_r    <= 1'b1;
                            expired_r <= 1'b1;
                        end
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    running_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    // Display decode straight from the count registers (no added latency).
    always_comb begin
        HEX0 = seg7(ones_of({1'b0, sec_r}));
        HEX1 = seg7(tens_of({1'b0, sec_r}));
        HEX2 = seg7(ones_of(min_r));
        HEX3 = seg7(tens_of(min_r));
    end

    assign milesimos = ms_r;
    assign running   = running_r;
    assign done      = done_r;
    assign expired   = expired_r;

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//   Directed scenarios followed by randomized load/start activity. A
//   reference model tracks the remaining time as one millisecond total and
//   derives every expected output from that total. The bench runs with
//   TICK_DIV = 4.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic       load;
    logic [6:0] preset_min;
    logic [5:0] preset_sec;
    logic       start;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;
    logic [9:0] milesimos;
    logic       running, done, expired;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: mode 0 idle, 1 run, 2 pause, 3 done
    int m_mode;
    int m_t;
    int m_ph;
    bit m_exp;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    countdown_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .load(load), .preset_min(preset_min),
        .preset_sec(preset_sec), .start(start), .HEX0(HEX0), .HEX1(HEX1),
        .HEX2(HEX2), .HEX3(HEX3), .milesimos(milesimos), .running(running),
        .done(done), .expired(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_t    = 0;
        m_ph   = 0;
        m_exp  = 1'b0;
    endtask

    // One clock edge of the reference model, based on the inputs at that edge.
    task automatic model_step();
        int pm, ps;
        m_exp = 1'b0;
        if (load) begin
            pm     = (preset_min > 7'd99) ? 99 : int'(preset_min);
            ps     = (preset_sec > 6'd59) ? 59 : int'(preset_sec);
            m_t    = pm * 60000 + ps * 1000;
            m_mode = 0;
            m_ph   = 0;
        end else begin
            case (m_mode)
                0: if (start && m_t > 0) m_mode = 1;
                1: begin
                    if (!start) begin
                        m_mode = 2;
                    end else begin
                        m_ph++;
                        if (m_ph == TD) begin
                            m_ph = 0;
                            m_t--;
                            if (m_t == 0) begin
                                m_mode = 3;
                                m_exp  = 1'b1;
                            end
                        end
                    end
                end
                2: if (start) m_mode = 1;
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        int mm, ss;
        mm = m_t / 60000;
        ss = (m_t / 1000) % 60;
        check_eq("running",   32'(running),   32'(m_mode == 1));
        check_eq("done",      32'(done),      32'(m_mode == 3));
        check_eq("expired",   32'(expired),   32'(m_exp));
        check_eq("milesimos", 32'(milesimos), 32'(m_t % 1000));
        check_eq("HEX0",      32'(HEX0),      32'(seg_tab[ss % 10]));
        check_eq("HEX1",      32'(HEX1),      32'(seg_tab[ss / 10]));
        check_eq("HEX2",      32'(HEX2),      32'(seg_tab[mm % 10]));
        check_eq("HEX3",      32'(HEX3),      32'(seg_tab[mm / 10]));
    endtask

    // Advance one clock, update the model, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic mid_reset();
        #2 rst = 1'b0;
        #1;
        check_eq("rst_hex0",  32'(HEX0), 32'h40);
        check_eq("rst_hex1",  32'(HEX1), 32'h40);
        check_eq("rst_hex2",  32'(HEX2), 32'h40);
        check_eq("rst_hex3",  32'(HEX3), 32'h40);
        check_eq("rst_ms",    32'(milesimos), 32'd0);
        check_eq("rst_done",  32'(done), 32'd0);
        check_eq("rst_run",   32'(running), 32'd0);
        check_eq("rst_exp",   32'(expired), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int n, pulses, p;
        logic [9:0] frozen;

        rst = 1'b0; load = 1'b0; start = 1'b0;
        preset_min = 7'd0; preset_sec = 6'd0;
        model_reset();
        #3;
        check_eq("init_hex0", 32'(HEX0), 32'h40);
        check_eq("init_ms",   32'(milesimos), 32'd0);
        check_eq("init_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 0:01 countdown to DONE
        load = 1'b1; preset_min = 7'd0; preset_sec = 6'd1;
        step();
        load = 1'b0; start = 1'b1;
        step();
        check_eq("run_next_cycle", 32'(running), 32'd1);
        for (int i = 0; i < 4; i++) step();
        check_eq("first_dec_ms",  32'(milesimos), 32'd999);
        check_eq("first_dec_sec", 32'(HEX0), 32'h40);
        n = 4; pulses = 0;
        while (!done && n < 5000) begin
            step();
            n++;
            if (expired) pulses++;
        end
        check_eq("done_latency", 32'(n), 32'd4000);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            step();
            if (expired) pulses++;
        end
        check_eq("expired_pulses", 32'(pulses), 32'd1);
        check_eq("done_held", 32'(done), 32'd1);
        check_eq("done_hex3", 32'(HEX3), 32'h40);
        check_eq("done_hex2", 32'(HEX2), 32'h40);
        check_eq("done_hex1", 32'(HEX1), 32'h40);
        check_eq("done_hex0", 32'(HEX0), 32'h40);

        // load 0:00 from DONE, start held: stays IDLE, never expires
        load = 1'b1; preset_min = 7'd0; preset_sec = 6'd0; start = 1'b1;
        step();
        check_eq("load_clears_done", 32'(done), 32'd0);
        load = 1'b0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (expired || running || done) pulses++;
        end
        check_eq("zero_stays_idle", 32'(pulses), 32'd0);

        // pause / resume preserves prescaler phase
        load = 1'b1; preset_sec = 6'd2; start = 1'b0;
        step();
        load = 1'b0; start = 1'b1;
        step();
        n = $urandom_range(900, 1100);
        for (int i = 0; i < n; i++) step();
        start = 1'b0;
        step();
        frozen = milesimos;
        p = m_ph;
        for (int i = 0; i < 100; i++) step();
        check_eq("pause_running", 32'(running), 32'd0);
        check_eq("pause_frozen",  32'(milesimos), 32'(frozen));
        start = 1'b1;
        step();
        check_eq("resume_running", 32'(running), 32'd1);
        n = 0;
        while (milesimos == frozen && n < 10) begin
            step();
            n++;
        end
        check_eq("resume_delay", 32'(n), 32'(TD - p));

        // clamp 120:63 -> 99:59
        load = 1'b1; preset_min = 7'd120; preset_sec = 6'd63; start = 1'b0;
        step();
        load = 1'b0;
        check_eq("clamp_hex3", 32'(HEX3), 32'h10);
        check_eq("clamp_hex2", 32'(HEX2), 32'h10);
        check_eq("clamp_hex1", 32'(HEX1), 32'h12);
        check_eq("clamp_hex0", 32'(HEX0), 32'h10);

        // reload 2:30 while running
        start = 1'b1;
        for (int i = 0; i < 9; i++) step();
        load = 1'b1; preset_min = 7'd2; preset_sec = 6'd30;
        step();
        load = 1'b0;
        check_eq("reload_idle", 32'(running), 32'd0);
        check_eq("reload_ms",   32'(milesimos), 32'd0);
        check_eq("reload_hex3", 32'(HEX3), 32'h40);
        check_eq("reload_hex2", 32'(HEX2), 32'h24);
        check_eq("reload_hex1", 32'(HEX1), 32'h30);
        check_eq("reload_hex0", 32'(HEX0), 32'h40);
        step();
        check_eq("reload_run", 32'(running), 32'd1);

        // reset mid-count, then no restart without a load
        for (int i = 0; i < 50; i++) step();
        mid_reset();
        for (int i = 0; i < 20; i++) step();
        check_eq("post_reset_idle", 32'(running), 32'd0);

        // randomized activity
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 1499) == 0) begin
                load = 1'b1;
                preset_min = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
                preset_sec = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                         : 6'($urandom_range(0, 1));
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 63) == 0) start = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4999) == 0) mid_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
